// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests under a credit limit,
// buffers returned words with their PCs, and discards responses made stale by EX redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc
);

    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] kill_cnt_q, kill_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [31:0]   tag_q [FIFO_DEPTH];
    logic [31:0]   tag_d [FIFO_DEPTH];
    logic [PW-1:0] tag_wr_q, tag_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;

    logic [31:0]   buf_pc_q    [FIFO_DEPTH];
    logic [31:0]   buf_pc_d    [FIFO_DEPTH];
    logic [31:0]   buf_instr_q [FIFO_DEPTH];
    logic [31:0]   buf_instr_d [FIFO_DEPTH];
    logic [PW-1:0] buf_wr_q, buf_wr_d;
    logic [PW-1:0] buf_rd_q, buf_rd_d;

    logic [CW:0]   in_use;
    logic          credit_ok;
    logic          accept;
    logic          rsp;
    logic          rsp_keep;
    logic          pop;
    logic          redirect_pc_unused;

    // Target is always word aligned; the low bits of the redirect target carry no information.
    assign redirect_pc_unused = ^redirect_pc[1:0];

    always_comb begin
        in_use    = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
        credit_ok = in_use < DEPTH_W;
        imem_req  = !rst && !redirect && credit_ok;
        accept    = imem_req && imem_ready;
        rsp       = imem_rvalid && (out_cnt_q != '0);
        rsp_keep  = rsp && (kill_cnt_q == '0) && !redirect;
        if_valid  = fifo_cnt_q != '0;
        pop       = if_valid && !stall && !redirect;
    end

    assign imem_addr   = fetch_pc_q;
    assign instruction = if_valid ? buf_instr_q[buf_rd_q] : NOP_INSTR;
    assign pc          = if_valid ? buf_pc_q[buf_rd_q] : 32'h0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        out_cnt_d = out_cnt_q + CW'(accept) - CW'(rsp);

        // Every request still outstanding after a redirect belongs to the abandoned path,
        // so the kill count becomes exactly what is left in flight (second redirect wins).
        kill_cnt_d = kill_cnt_q;
        if (redirect) begin
            kill_cnt_d = out_cnt_q - CW'(rsp);
        end else if (rsp && (kill_cnt_q != '0)) begin
            kill_cnt_d = kill_cnt_q - CW'(1);
        end
    end

    always_comb begin
        tag_d    = tag_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        if (accept) begin
            tag_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d        = ptr_inc(tag_wr_q);
        end
        if (rsp) begin
            tag_rd_d = ptr_inc(tag_rd_q);
        end
    end

    always_comb begin
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_wr_d    = buf_wr_q;
        buf_rd_d    = buf_rd_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (redirect) begin
            buf_wr_d   = '0;
            buf_rd_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (rsp_keep) begin
                buf_pc_d[buf_wr_q]    = tag_q[tag_rd_q];
                buf_instr_d[buf_wr_q] = imem_rdata;
                buf_wr_d              = ptr_inc(buf_wr_q);
            end
            if (pop) begin
                buf_rd_d = ptr_inc(buf_rd_q);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= '0;
            kill_cnt_q <= '0;
            fifo_cnt_q <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_q[i]       <= '0;
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            out_cnt_q   <= out_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
            fifo_cnt_q  <= fifo_cnt_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            buf_wr_q    <= buf_wr_d;
            buf_rd_q    <= buf_rd_d;
            tag_q       <= tag_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: an in-order imem model with optional hold drives each scenario;
// every cycle's request and ID-side output are compared against hand-derived tables.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .if_valid   (if_valid),
        .instruction(instruction),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rd;
        logic [31:0] rpc;
        logic        hold;
        logic        req;
        logic [31:0] addr;
        logic        val;
        logic [31:0] pc;
    } row_t;

    int          n_vec;
    int          n_fail;
    logic [31:0] mq[$];
    logic        mem_en;
    logic        mem_hold;
    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // One clock: observe mid-cycle, record accepts, then drive next-cycle memory response.
    task automatic cyc();
        @(negedge clk);
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = if_valid;
        obs_pc    = pc;
        obs_instr = instruction;
        if (imem_req && imem_ready) mq.push_back(imem_addr);
        @(posedge clk);
        #1;
        if (mem_en) begin
            if (!mem_hold && mq.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    endtask

    task automatic run_row(input row_t r);
        stall       = r.stall;
        redirect    = r.rd;
        redirect_pc = r.rpc;
        mem_hold    = r.hold;
        cyc();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_en      = 1'b1;
        mem_hold    = 1'b0;
        mq.delete();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_en      = 1'b1;
        mem_hold    = 1'b0;
        cyc();
        n_vec++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset req: got %b want 0", obs_req); end
        n_vec++; if (obs_addr !== 32'h0) begin n_fail++; $display("FAIL reset addr: got %h want 00000000", obs_addr); end
        n_vec++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", obs_valid); end
        n_vec++; if (obs_instr !== NOP) begin n_fail++; $display("FAIL reset instr: got %h want %h", obs_instr, NOP); end
        n_vec++; if (obs_pc !== 32'h0) begin n_fail++; $display("FAIL reset pc: got %h want 00000000", obs_pc); end
    endtask

    task automatic test_stream();
        row_t t [7];
        do_reset();
        t = '{'{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8,  1'b1, 32'h4},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC,  1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b1, 32'hC}};
        for (int i = 0; i < 7; i++) begin
            run_row(t[i]);
            n_vec++;
            if (obs_req !== t[i].req || (t[i].req && obs_addr !== t[i].addr)) begin
                n_fail++; $display("FAIL stream c%0d req/addr: got %b/%h want %b/%h", i, obs_req, obs_addr, t[i].req, t[i].addr);
            end
            n_vec++;
            if (obs_valid !== t[i].val || obs_pc !== (t[i].val ? t[i].pc : 32'h0) || obs_instr !== (t[i].val ? mem_word(t[i].pc) : NOP)) begin
                n_fail++; $display("FAIL stream c%0d out: got %b/%h/%h want %b/%h", i, obs_valid, obs_pc, obs_instr, t[i].val, t[i].pc);
            end
        end
    endtask

    task automatic test_stall();
        row_t t [9];
        do_reset();
        t = '{'{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0},
              '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0},
              '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0},
              '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0},
              '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8}};
        for (int i = 0; i < 9; i++) begin
            run_row(t[i]);
            n_vec++;
            if (obs_req !== t[i].req || (t[i].req && obs_addr !== t[i].addr)) begin
                n_fail++; $display("FAIL stall c%0d req/addr: got %b/%h want %b/%h", i, obs_req, obs_addr, t[i].req, t[i].addr);
            end
            n_vec++;
            if (obs_valid !== t[i].val || obs_pc !== (t[i].val ? t[i].pc : 32'h0) || obs_instr !== (t[i].val ? mem_word(t[i].pc) : NOP)) begin
                n_fail++; $display("FAIL stall c%0d out: got %b/%h/%h want %b/%h", i, obs_valid, obs_pc, obs_instr, t[i].val, t[i].pc);
            end
        end
    endtask

    task automatic test_redirect_inflight();
        row_t t [8];
        do_reset();
        t = '{'{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0},
              '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 32'h104}};
        for (int i = 0; i < 8; i++) begin
            run_row(t[i]);
            n_vec++;
            if (obs_req !== t[i].req || (t[i].req && obs_addr !== t[i].addr)) begin
                n_fail++; $display("FAIL redir_inflight c%0d req/addr: got %b/%h want %b/%h", i, obs_req, obs_addr, t[i].req, t[i].addr);
            end
            n_vec++;
            if (obs_valid !== t[i].val || obs_pc !== (t[i].val ? t[i].pc : 32'h0) || obs_instr !== (t[i].val ? mem_word(t[i].pc) : NOP)) begin
                n_fail++; $display("FAIL redir_inflight c%0d out: got %b/%h/%h want %b/%h", i, obs_valid, obs_pc, obs_instr, t[i].val, t[i].pc);
            end
        end
    endtask

    task automatic test_redirect_rsp_stall();
        row_t t [9];
        do_reset();
        t = '{'{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, 32'h0},
              '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1'b0, 32'h0},
              '{1'b1, 1'b1, 32'h103, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0},
              '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0},
              '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 32'h0},
              '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100},
              '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 32'h104}};
        for (int i = 0; i < 9; i++) begin
            run_row(t[i]);
            n_vec++;
            if (obs_req !== t[i].req || (t[i].req && obs_addr !== t[i].addr)) begin
                n_fail++; $display("FAIL redir_rsp_stall c%0d req/addr: got %b/%h want %b/%h", i, obs_req, obs_addr, t[i].req, t[i].addr);
            end
            n_vec++;
            if (obs_valid !== t[i].val || obs_pc !== (t[i].val ? t[i].pc : 32'h0) || obs_instr !== (t[i].val ? mem_word(t[i].pc) : NOP)) begin
                n_fail++; $display("FAIL redir_rsp_stall c%0d out: got %b/%h/%h want %b/%h", i, obs_valid, obs_pc, obs_instr, t[i].val, t[i].pc);
            end
        end
    endtask

    task automatic test_pc_wrap();
        row_t t [5];
        do_reset();
        t = '{'{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC},
              '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b1, 32'h0}};
        for (int i = 0; i < 5; i++) begin
            run_row(t[i]);
            n_vec++;
            if (obs_req !== t[i].req || (t[i].req && obs_addr !== t[i].addr)) begin
                n_fail++; $display("FAIL pc_wrap c%0d req/addr: got %b/%h want %b/%h", i, obs_req, obs_addr, t[i].req, t[i].addr);
            end
            n_vec++;
            if (obs_valid !== t[i].val || obs_pc !== (t[i].val ? t[i].pc : 32'h0) || obs_instr !== (t[i].val ? mem_word(t[i].pc) : NOP)) begin
                n_fail++; $display("FAIL pc_wrap c%0d out: got %b/%h/%h want %b/%h", i, obs_valid, obs_pc, obs_instr, t[i].val, t[i].pc);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t t [8];
        do_reset();
        t = '{'{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0},
              '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0},
              '{1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300, 1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h304, 1'b0, 32'h0},
              '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h300}};
        for (int i = 0; i < 8; i++) begin
            run_row(t[i]);
            n_vec++;
            if (obs_req !== t[i].req || (t[i].req && obs_addr !== t[i].addr)) begin
                n_fail++; $display("FAIL back_to_back c%0d req/addr: got %b/%h want %b/%h", i, obs_req, obs_addr, t[i].req, t[i].addr);
            end
            n_vec++;
            if (obs_valid !== t[i].val || obs_pc !== (t[i].val ? t[i].pc : 32'h0) || obs_instr !== (t[i].val ? mem_word(t[i].pc) : NOP)) begin
                n_fail++; $display("FAIL back_to_back c%0d out: got %b/%h/%h want %b/%h", i, obs_valid, obs_pc, obs_instr, t[i].val, t[i].pc);
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        mem_hold = 1'b1;
        cyc();
        cyc();
        n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin n_fail++; $display("FAIL rst_mid prefill: got %b/%h want 1/00000004", obs_req, obs_addr); end
        // Reset with two requests outstanding; a response arrives during reset.
        rst         = 1'b1;
        mem_en      = 1'b0;
        mq.delete();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        cyc();
        n_vec++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid in_reset req: got %b want 0", obs_req); end
        n_vec++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid in_reset valid: got %b want 0", obs_valid); end
        // Late response after release while nothing is outstanding.
        rst         = 1'b0;
        imem_ready  = 1'b0;
        imem_rdata  = 32'hBAD1_BAD1;
        cyc();
        n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid late req/addr: got %b/%h want 1/00000000", obs_req, obs_addr); end
        n_vec++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid late valid: got %b want 0", obs_valid); end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        imem_ready  = 1'b1;
        mem_hold    = 1'b0;
        mem_en      = 1'b1;
        mq.delete();
        cyc();
        n_vec++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid ignored valid: got %b want 0", obs_valid); end
        n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid first req/addr: got %b/%h want 1/00000000", obs_req, obs_addr); end
        cyc();
        n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin n_fail++; $display("FAIL rst_mid second req/addr: got %b/%h want 1/00000004", obs_req, obs_addr); end
        cyc();
        n_vec++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid first out: got %b/%h want 1/00000000", obs_valid, obs_pc); end
        n_vec++; if (obs_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL rst_mid first instr: got %h want %h", obs_instr, mem_word(32'h0)); end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_rsp_stall();
        test_pc_wrap();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
